// File: rtl/hazard_scoreboard.sv
// Issue-stage RAW/WAW scoreboard driving the exe-stage WB bypass selects.
// Optional stall-cycle counter built when HAZARD_SCOREBOARD_PERF_EN is defined.
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int LAT_W    = 3
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             issue_valid_i,
    input  logic             issue_we_i,
    input  logic [4:0]       issue_rd_i,
    input  logic [LAT_W-1:0] issue_lat_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic             rs1_used_i,
    input  logic             rs2_used_i,
    input  logic             wb_valid_i,
    input  logic [4:0]       wb_rd_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             bypass_rs1_o,
    output logic             bypass_rs2_o,
    output logic             busy_o,
    output logic [31:0]      stall_cnt_o
);

    // Handshake: an instruction is accepted on any edge where issue_valid_i is
    // high and stall_o is low; decode must hold it unchanged while stalled.

    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] var_q;
    logic [LAT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] ready_bp;

    logic rs1_hit, rs2_hit, rd_hit;
    logic rs1_haz, rs2_haz, waw_haz;
    logic accept;

    // An entry can be consumed via the bypass in the cycle its producer is in WB.
    always_comb begin
        ready_bp = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            ready_bp[r] = pend[r] &
                          ((!var_q[r] && cnt[r] == LAT_W'(1)) ||
                           (var_q[r] && wb_valid_i && wb_rd_i == 5'(r)));
        end
    end

    always_comb begin
        rs1_hit = rs1_used_i && rs1_i != 5'd0 && pend[rs1_i];
        rs2_hit = rs2_used_i && rs2_i != 5'd0 && pend[rs2_i];
        rd_hit  = issue_we_i && issue_rd_i != 5'd0 && pend[issue_rd_i];
        rs1_haz = rs1_hit && !ready_bp[rs1_i];
        rs2_haz = rs2_hit && !ready_bp[rs2_i];
        waw_haz = rd_hit && !ready_bp[issue_rd_i];
        bypass_rs1_o = rs1_hit && ready_bp[rs1_i];
        bypass_rs2_o = rs2_hit && ready_bp[rs2_i];
        stall_o = issue_valid_i && (rs1_haz || rs2_haz || waw_haz);
        busy_o  = |pend;
        accept  = issue_valid_i && !stall_o && !flush_i && issue_we_i && issue_rd_i != 5'd0;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            pend  <= '0;
            var_q <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                // A new allocation overrides any retirement of the same entry.
                if (accept && issue_rd_i == 5'(r)) begin
                    pend[r]  <= 1'b1;
                    var_q[r] <= (issue_lat_i == '0);
                    cnt[r]   <= issue_lat_i;
                end else if (pend[r] && !var_q[r]) begin
                    if (flush_i || cnt[r] <= LAT_W'(1)) begin
                        pend[r] <= 1'b0;
                        cnt[r]  <= '0;
                    end else begin
                        cnt[r] <= cnt[r] - LAT_W'(1);
                    end
                end else if (pend[r] && var_q[r] && wb_valid_i && wb_rd_i == 5'(r)) begin
                    pend[r]  <= 1'b0;
                    var_q[r] <= 1'b0;
                end
            end
        end
    end

`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            stall_cnt_q <= '0;
        end else if (stall_o && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule
